// File: rtl/autobaud_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : autobaud_ctrl
// Brief    : Measures a 0x55 sync character on RX and programs baud_gen.
// Revision : 1.0 - initial release
// ============================================================================
module autobaud_ctrl #(
    parameter int OSR   = 16,
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             en_i,
    input  logic             start_i,
    input  logic             rx_i,
    output logic [DIV_W-1:0] div_o,
    output logic             baud_en_o,
    output logic             busy_o,
    output logic             locked_o,
    output logic             err_o,
    output logic             done_o
);

    localparam logic [2:0] c_S_IDLE       = 3'd0;
    localparam logic [2:0] c_S_WAIT_START = 3'd1;
    localparam logic [2:0] c_S_MEASURE    = 3'd2;
    localparam logic [2:0] c_S_WAIT_STOP  = 3'd3;
    localparam logic [2:0] c_S_LOCKED     = 3'd4;

    localparam int               c_SHIFT   = $clog2(8 * OSR);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_ROUND   = CNT_W'(4 * OSR);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_DIV_MAX = CNT_W'((2 ** DIV_W) - 1);

    logic [2:0]       r_state, w_state_nxt;
    logic             r_rx_q;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_seg, w_seg_nxt;
    logic [2:0]       r_edge_n, w_edge_nxt;
    logic [CNT_W-1:0] r_i1, w_i1_nxt;
    logic             r_mis, w_mis_nxt;
    logic [CNT_W-1:0] r_total, w_total_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic             r_err, w_err_nxt;
    logic             r_done, w_done_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_locked, w_locked_nxt;

    logic             w_fall, w_rise;
    logic [CNT_W-1:0] w_cnt_inc, w_seg_inc, w_interval, w_diff;
    logic [CNT_W-1:0] w_div_sum, w_div_calc;
    logic             w_mis_now, w_div_ok;

    assign w_fall     = r_rx_q & ~rx_i;
    assign w_rise     = ~r_rx_q & rx_i;
    assign w_cnt_inc  = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_ONE;
    assign w_seg_inc  = (r_seg == c_CNT_MAX) ? r_seg : r_seg + c_ONE;
    assign w_interval = r_seg + c_ONE;
    assign w_diff     = (w_interval >= r_i1) ? (w_interval - r_i1) : (r_i1 - w_interval);
    assign w_mis_now  = w_diff > (r_i1 >> 2);
    // Total spans 8 bit periods, so dividing by 8*OSR yields the divisor; +4*OSR rounds.
    assign w_div_sum  = r_total + c_ROUND;
    assign w_div_calc = w_div_sum >> c_SHIFT;
    assign w_div_ok   = (w_div_calc != '0) && (w_div_calc <= c_DIV_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_seg_nxt   = r_seg;
        w_edge_nxt  = r_edge_n;
        w_i1_nxt    = r_i1;
        w_mis_nxt   = r_mis;
        w_total_nxt = r_total;
        w_div_nxt   = r_div;
        w_err_nxt   = r_err;
        w_done_nxt  = 1'b0;
        if (!en_i) begin
            w_state_nxt = c_S_IDLE;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start_i) begin
                        w_state_nxt = c_S_WAIT_START;
                        w_err_nxt   = 1'b0;
                    end
                end
                c_S_WAIT_START: begin
                    if (w_fall) begin
                        w_cnt_nxt   = '0;
                        w_seg_nxt   = '0;
                        w_edge_nxt  = 3'd1;
                        w_mis_nxt   = 1'b0;
                        w_state_nxt = c_S_MEASURE;
                    end
                end
                c_S_MEASURE: begin
                    w_cnt_nxt = w_cnt_inc;
                    w_seg_nxt = w_seg_inc;
                    if (w_cnt_inc == c_CNT_MAX) begin
                        w_state_nxt = c_S_IDLE;
                        w_err_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else if (w_fall) begin
                        w_seg_nxt  = '0;
                        w_edge_nxt = r_edge_n + 3'd1;
                        if (r_edge_n == 3'd1) begin
                            w_i1_nxt = w_interval;
                        end else if (w_mis_now) begin
                            w_mis_nxt = 1'b1;
                        end
                        if (r_edge_n == 3'd4) begin
                            w_total_nxt = r_cnt + c_ONE;
                            w_state_nxt = c_S_WAIT_STOP;
                        end
                    end
                end
                c_S_WAIT_STOP: begin
                    if (w_rise) begin
                        w_done_nxt = 1'b1;
                        if (!r_mis && w_div_ok) begin
                            w_div_nxt   = w_div_calc[DIV_W-1:0];
                            w_state_nxt = c_S_LOCKED;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = c_S_IDLE;
                        end
                    end
                end
                c_S_LOCKED: begin
                    if (start_i) begin
                        w_state_nxt = c_S_WAIT_START;
                    end
                end
                default: w_state_nxt = c_S_IDLE;
            endcase
        end
        w_busy_nxt   = (w_state_nxt == c_S_WAIT_START) || (w_state_nxt == c_S_MEASURE) ||
                       (w_state_nxt == c_S_WAIT_STOP);
        w_locked_nxt = (w_state_nxt == c_S_LOCKED);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state  <= c_S_IDLE;
            r_rx_q   <= 1'b1;
            r_cnt    <= '0;
            r_seg    <= '0;
            r_edge_n <= 3'd0;
            r_i1     <= '0;
            r_mis    <= 1'b0;
            r_total  <= '0;
            r_div    <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rx_q   <= rx_i;
            r_cnt    <= w_cnt_nxt;
            r_seg    <= w_seg_nxt;
            r_edge_n <= w_edge_nxt;
            r_i1     <= w_i1_nxt;
            r_mis    <= w_mis_nxt;
            r_total  <= w_total_nxt;
            r_div    <= w_div_nxt;
            r_err    <= w_err_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            r_locked <= w_locked_nxt;
        end
    end

    // baud_gen runs only while locked, so the divisor never changes under it.
    assign div_o     = r_div;
    assign baud_en_o = r_locked;
    assign busy_o    = r_busy;
    assign locked_o  = r_locked;
    assign err_o     = r_err;
    assign done_o    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_autobaud_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_autobaud_ctrl
// Brief    : Self-checking bench for autobaud_ctrl (table vectors + sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_autobaud_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, en, start, rx;
    logic [7:0] div;
    logic       baud_en, busy, locked, err, done;

    logic       en2, start2, rx2;
    logic [7:0] div2;
    logic       baud_en2, busy2, locked2, err2, done2;

    autobaud_ctrl #(.OSR(16), .DIV_W(8), .CNT_W(16)) dut (
        .clk_i(clk), .reset_ni(reset_n), .en_i(en), .start_i(start), .rx_i(rx),
        .div_o(div), .baud_en_o(baud_en), .busy_o(busy), .locked_o(locked),
        .err_o(err), .done_o(done)
    );

    // Narrow counter so saturation is reachable in a short run.
    autobaud_ctrl #(.OSR(16), .DIV_W(8), .CNT_W(12)) dut_sat (
        .clk_i(clk), .reset_ni(reset_n), .en_i(en2), .start_i(start2), .rx_i(rx2),
        .div_o(div2), .baud_en_o(baud_en2), .busy_o(busy2), .locked_o(locked2),
        .err_o(err2), .done_o(done2)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        int p;
        int extra;
        bit lock;
        int exp_div;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic arm();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // 0x55 8N1: bits 0..8 alternate 0/1 starting with the start bit; bit 5 may be stretched.
    task automatic send_frame(input int p, input int extra);
        for (int b = 0; b < 9; b++) begin
            rx = b[0];
            repeat (p + ((b == 5) ? extra : 0)) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int base;
        int m;
        reset_n = 1'b0; en = 1'b1; start = 1'b0; rx = 1'b1;
        en2 = 1'b1; start2 = 1'b0; rx2 = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("rst_div", div, 0);
        check("rst_baud_en", baud_en, 0);
        check("rst_locked", locked, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);

        vecs[0] = '{p: 64,   extra: 0,  lock: 1'b1, exp_div: 4};
        vecs[1] = '{p: 67,   extra: 0,  lock: 1'b1, exp_div: 4};
        vecs[2] = '{p: 200,  extra: 0,  lock: 1'b1, exp_div: 13};
        vecs[3] = '{p: 64,   extra: 0,  lock: 1'b1, exp_div: 4};
        vecs[4] = '{p: 64,   extra: 64, lock: 1'b0, exp_div: 4};
        vecs[5] = '{p: 4,    extra: 0,  lock: 1'b0, exp_div: 4};
        vecs[6] = '{p: 4200, extra: 0,  lock: 1'b0, exp_div: 4};

        for (int i = 0; i < 7; i++) begin
            arm();
            check("arm_busy", busy, 1);
            check("arm_locked", locked, 0);
            check("arm_baud_en", baud_en, 0);
            check("arm_err", err, 0);
            base = done_cnt;
            send_frame(vecs[i].p, vecs[i].extra);
            check("vec_done_pulses", done_cnt - base, 1);
            check("vec_div", div, vecs[i].exp_div);
            check("vec_err", err, !vecs[i].lock);
            check("vec_locked", locked, vecs[i].lock);
            check("vec_baud_en", baud_en, vecs[i].lock);
            check("vec_busy", busy, 0);
        end

        // Abort: en_i low for one cycle during MEASURE.
        arm();
        rx = 1'b0;
        repeat (10) @(negedge clk);
        base = done_cnt;
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_err", err, 0);
        check("abort_locked", locked, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt - base, 0);
        check("abort_idle", busy, 0);
        check("abort_div_hold", div, 4);

        // start_i during MEASURE must be ignored.
        arm();
        base = done_cnt;
        fork
            send_frame(64, 0);
            begin
                repeat (200) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("ign_busy", busy, 1);
            end
        join
        check("ign_done_pulses", done_cnt - base, 1);
        check("ign_locked", locked, 1);
        check("ign_div", div, 4);
        check("ign_err", err, 0);

        // Counter saturation before the stop bit (narrow-counter instance).
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("sat_arm_busy", busy2, 1);
        rx2 = 1'b0;
        m = 0;
        while (!done2 && m < 5000) begin
            @(negedge clk);
            m++;
        end
        check("sat_done", done2, 1);
        check("sat_err", err2, 1);
        check("sat_busy", busy2, 0);
        check("sat_locked", locked2, 0);
        check("sat_div", div2, 0);
        check("sat_latency_ok", (m >= 4090 && m <= 4100), 1);
        @(negedge clk);
        check("sat_done_single", done2, 0);
        rx2 = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
